// File: rtl/nic_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nic_pkg
// Purpose : Shared constants for the ring-node NIC (register map, packet
//           fields, injection FSM states, status word packing).
// Rev     : 1.0
// ============================================================================
package nic_pkg;

    localparam logic [1:0] ADDR_IN_DATA  = 2'd0;
    localparam logic [1:0] ADDR_IN_STAT  = 2'd1;
    localparam logic [1:0] ADDR_OUT_DATA = 2'd2;
    localparam logic [1:0] ADDR_OUT_STAT = 2'd3;

    localparam int VC_BIT  = 63;
    localparam int DIR_BIT = 62;
    localparam int HOP_MSB = 55;
    localparam int HOP_LSB = 48;

    typedef logic [0:0] nic_state_t;
    localparam nic_state_t ST_IDLE = 1'b0;
    localparam nic_state_t ST_SEND = 1'b1;

    function automatic logic [63:0] status_word(input logic [7:0] occ, input logic flag);
        return {48'b0, occ, 7'b0, flag};
    endfunction

endpackage
`default_nettype wire

// File: rtl/nic_fifo.sv
`default_nettype none
// ============================================================================
// Module  : nic_fifo
// Purpose : Power-of-two circular FIFO; push when full and pop when empty
//           are ignored, so callers may drive raw requests.
// Rev     : 1.0
// ============================================================================
module nic_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == C_FULL_COUNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    // Full/empty are judged on pre-edge state, so a simultaneous pop never frees a slot for a push.
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/nic.sv
`default_nettype none
// ============================================================================
// Module  : nic
// Purpose : PE-side network interface: buffers PE packets for phase-aligned
//           injection into the router and holds ejected packets for the PE.
// Rev     : 1.0
// ============================================================================
module nic
    import nic_pkg::*;
#(
    parameter int OUT_DEPTH = 4,
    parameter int IN_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic [63:0] d_in,
    output logic [63:0] d_out,
    input  logic        nicEn,
    input  logic        nicEnWr,
    input  logic        net_polarity,
    output logic        net_si,
    output logic [63:0] net_do,
    input  logic        net_ri,
    input  logic        net_so,
    input  logic [63:0] net_di,
    output logic        net_ro
);

    localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;
    localparam int IN_CW  = $clog2(IN_DEPTH) + 1;

    logic [63:0]       w_out_head;
    logic              w_out_full;
    logic              w_out_empty;
    logic [OUT_CW-1:0] w_out_count;
    logic [63:0]       w_in_head;
    logic              w_in_full;
    logic              w_in_empty;
    logic [IN_CW-1:0]  w_in_count;

    logic              w_pe_wr;
    logic              w_pe_rd;
    logic              w_send_ok;
    logic [63:0]       w_d_out;

    nic_state_t        r_state;
    logic [63:0]       r_net_do;

    assign w_pe_wr = nicEn & nicEnWr & (addr == ADDR_OUT_DATA);
    assign w_pe_rd = nicEn & ~nicEnWr;

    // The router flips polarity at this edge, so the head's VC must equal the *next* phase.
    assign w_send_ok = ~w_out_empty & net_ri & (w_out_head[VC_BIT] != net_polarity);

    nic_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(64)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_pe_wr),
        .pop   (w_send_ok),
        .din   (d_in),
        .head  (w_out_head),
        .full  (w_out_full),
        .empty (w_out_empty),
        .count (w_out_count)
    );

    nic_fifo #(.DEPTH(IN_DEPTH), .WIDTH(64)) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (net_so),
        .pop   (w_pe_rd & (addr == ADDR_IN_DATA)),
        .din   (net_di),
        .head  (w_in_head),
        .full  (w_in_full),
        .empty (w_in_empty),
        .count (w_in_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_net_do <= '0;
        end else if (w_send_ok) begin
            r_state  <= ST_SEND;
            r_net_do <= w_out_head;
        end else begin
            r_state  <= ST_IDLE;
            r_net_do <= '0;
        end
    end

    always_comb begin
        w_d_out = '0;
        if (w_pe_rd) begin
            case (addr)
                ADDR_IN_DATA:  w_d_out = w_in_empty ? 64'd0 : w_in_head;
                ADDR_IN_STAT:  w_d_out = status_word(8'(w_in_count), ~w_in_empty);
                ADDR_OUT_STAT: w_d_out = status_word(8'(w_out_count), w_out_full);
                default:       w_d_out = '0;
            endcase
        end
    end

    assign d_out  = w_d_out;
    assign net_si = (r_state == ST_SEND);
    assign net_do = r_net_do;
    assign net_ro = ~w_in_full;

endmodule
`default_nettype wire

// File: tb/tb_nic.sv
`default_nettype none
// ============================================================================
// Module  : tb_nic
// Purpose : Directed self-checking bench for the ring-node NIC.
// Rev     : 1.0
// ============================================================================
module tb_nic;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic [63:0] d_in = '0;
    logic [63:0] d_out;
    logic        nicEn = 1'b0;
    logic        nicEnWr = 1'b0;
    logic        net_polarity = 1'b0;
    logic        net_si;
    logic [63:0] net_do;
    logic        net_ri = 1'b0;
    logic        net_so = 1'b0;
    logic [63:0] net_di = '0;
    logic        net_ro;

    int asserts  = 0;
    int failures = 0;

    nic #(.OUT_DEPTH(4), .IN_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicEnWr      (nicEnWr),
        .net_polarity (net_polarity),
        .net_si       (net_si),
        .net_do       (net_do),
        .net_ri       (net_ri),
        .net_so       (net_so),
        .net_di       (net_di),
        .net_ro       (net_ro)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1 net_polarity = ~net_polarity;
        end
    end

    always @(posedge clk) begin
        if (!reset && net_so && !net_ro) begin
            failures++;
            $display("FAIL protocol: net_so asserted while net_ro=%0b (required 1)", net_ro);
        end
    end

    // Callers are at a negedge; each access spans the following rising edge.
    task automatic pe_write(input logic [63:0] v);
        nicEn = 1'b1; nicEnWr = 1'b1; addr = 2'd2; d_in = v;
        @(negedge clk);
        nicEn = 1'b0; nicEnWr = 1'b0; d_in = '0;
    endtask

    task automatic pe_read(input logic [1:0] a, output logic [63:0] d);
        nicEn = 1'b1; nicEnWr = 1'b0; addr = a;
        #1 d = d_out;
        @(negedge clk);
        nicEn = 1'b0;
    endtask

    task automatic net_push(input logic [63:0] v);
        net_so = 1'b1; net_di = v;
        @(negedge clk);
        net_so = 1'b0; net_di = '0;
    endtask

    task automatic test_reset();
        logic [63:0] d;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        asserts++; if (net_si !== 1'b0) begin failures++; $display("FAIL reset_si: got %0b want 0", net_si); end
        asserts++; if (net_do !== 64'd0) begin failures++; $display("FAIL reset_do: got %h want 0", net_do); end
        asserts++; if (d_out !== 64'd0) begin failures++; $display("FAIL reset_dout: got %h want 0", d_out); end
        asserts++; if (net_ro !== 1'b1) begin failures++; $display("FAIL reset_ro: got %0b want 1", net_ro); end
        reset = 1'b0;
        @(negedge clk);
        pe_read(2'd3, d);
        asserts++; if (d !== 64'd0) begin failures++; $display("FAIL reset_out_stat: got %h want 0", d); end
        pe_read(2'd1, d);
        asserts++; if (d !== 64'd0) begin failures++; $display("FAIL reset_in_stat: got %h want 0", d); end
    endtask

    task automatic inject_one(input logic [63:0] pkt, input string name);
        bit seen = 0;
        net_ri = 1'b1;
        pe_write(pkt);
        for (int i = 0; i < 8 && !seen; i++) begin
            if (net_si === 1'b1) begin
                seen = 1;
                asserts++; if (net_do !== pkt) begin failures++; $display("FAIL %s_data: got %h want %h", name, net_do, pkt); end
                asserts++; if (net_polarity !== pkt[63]) begin failures++; $display("FAIL %s_phase: polarity %0b want %0b", name, net_polarity, pkt[63]); end
                @(negedge clk);
                asserts++; if (net_si !== 1'b0) begin failures++; $display("FAIL %s_pulse: net_si %0b want 0", name, net_si); end
                asserts++; if (net_do !== 64'd0) begin failures++; $display("FAIL %s_do_clear: got %h want 0", name, net_do); end
            end else begin
                @(negedge clk);
            end
        end
        asserts++; if (!seen) begin failures++; $display("FAIL %s_timeout: net_si never rose, want 1", name); end
    endtask

    task automatic test_injection();
        inject_one(64'h8000_0000_1234_5678, "inj_vc1");
        inject_one(64'h0000_0000_0BAD_CAFE, "inj_vc0");
    endtask

    task automatic test_out_full();
        logic [63:0] pkts [5];
        logic [63:0] d;
        int got = 0;
        pkts[0] = 64'h0000_0000_AAAA_0000;
        pkts[1] = 64'h8000_0000_AAAA_0001;
        pkts[2] = 64'h0000_0000_AAAA_0002;
        pkts[3] = 64'h8000_0000_AAAA_0003;
        pkts[4] = 64'h0000_0000_AAAA_0004;
        net_ri = 1'b0;
        for (int i = 0; i < 5; i++) pe_write(pkts[i]);
        pe_read(2'd3, d);
        asserts++; if (d !== 64'h0401) begin failures++; $display("FAIL full_stat: got %h want 0401", d); end
        net_ri = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (net_si === 1'b1) begin
                if (got < 4) begin
                    asserts++; if (net_do !== pkts[got]) begin failures++; $display("FAIL drain_%0d: got %h want %h", got, net_do, pkts[got]); end
                end
                got++;
            end
        end
        asserts++; if (got !== 4) begin failures++; $display("FAIL drain_count: got %0d want 4", got); end
        pe_read(2'd3, d);
        asserts++; if (d !== 64'h0) begin failures++; $display("FAIL drain_stat: got %h want 0", d); end
    endtask

    task automatic test_ejection();
        logic [63:0] d;
        for (int i = 0; i < 4; i++) net_push(64'h4000_0000_E000_0000 | 64'(i));
        asserts++; if (net_ro !== 1'b0) begin failures++; $display("FAIL ej_ro_full: got %0b want 0", net_ro); end
        pe_read(2'd1, d);
        asserts++; if (d !== 64'h0401) begin failures++; $display("FAIL ej_stat: got %h want 0401", d); end
        pe_read(2'd0, d);
        asserts++; if (d !== 64'h4000_0000_E000_0000) begin failures++; $display("FAIL ej_first: got %h want 40000000e0000000", d); end
        asserts++; if (net_ro !== 1'b1) begin failures++; $display("FAIL ej_ro_free: got %0b want 1", net_ro); end
        for (int i = 1; i < 4; i++) begin
            pe_read(2'd0, d);
            asserts++; if (d !== (64'h4000_0000_E000_0000 | 64'(i))) begin failures++; $display("FAIL ej_order_%0d: got %h", i, d); end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d;
        net_push(64'h0000_0000_5000_0000);
        net_push(64'h0000_0000_5000_0001);
        net_so = 1'b1; net_di = 64'h0000_0000_5000_0002;
        pe_read(2'd0, d);
        net_so = 1'b0; net_di = '0;
        asserts++; if (d !== 64'h0000_0000_5000_0000) begin failures++; $display("FAIL simul_pop: got %h want 50000000", d); end
        pe_read(2'd1, d);
        asserts++; if (d !== 64'h0201) begin failures++; $display("FAIL simul_occ: got %h want 0201", d); end
        pe_read(2'd0, d);
        asserts++; if (d !== 64'h0000_0000_5000_0001) begin failures++; $display("FAIL simul_order1: got %h want 50000001", d); end
        pe_read(2'd0, d);
        asserts++; if (d !== 64'h0000_0000_5000_0002) begin failures++; $display("FAIL simul_order2: got %h want 50000002", d); end
    endtask

    task automatic test_empty_read();
        logic [63:0] d;
        pe_read(2'd0, d);
        asserts++; if (d !== 64'd0) begin failures++; $display("FAIL empty_data: got %h want 0", d); end
        pe_read(2'd1, d);
        asserts++; if (d !== 64'd0) begin failures++; $display("FAIL empty_occ: got %h want 0", d); end
        pe_read(2'd2, d);
        asserts++; if (d !== 64'd0) begin failures++; $display("FAIL addr2_read: got %h want 0", d); end
    endtask

    task automatic test_reset_mid_send();
        logic [63:0] d;
        bit seen = 0;
        net_push(64'h0000_0000_CAFE_0001);
        net_ri = 1'b1;
        pe_write(64'h8000_0000_DEAD_0001);
        for (int i = 0; i < 8 && !seen; i++) begin
            if (net_si === 1'b1) seen = 1;
            else @(negedge clk);
        end
        asserts++; if (!seen) begin failures++; $display("FAIL midrst_timeout: net_si never rose, want 1"); end
        nicEn = 1'b1; nicEnWr = 1'b0; addr = 2'd0;
        #1;
        asserts++; if (d_out !== 64'h0000_0000_CAFE_0001) begin failures++; $display("FAIL midrst_pre: got %h want cafe0001", d_out); end
        reset = 1'b1;
        #1;
        asserts++; if (net_si !== 1'b0) begin failures++; $display("FAIL midrst_si: got %0b want 0", net_si); end
        asserts++; if (net_do !== 64'd0) begin failures++; $display("FAIL midrst_do: got %h want 0", net_do); end
        asserts++; if (d_out !== 64'd0) begin failures++; $display("FAIL midrst_dout: got %h want 0", d_out); end
        asserts++; if (net_ro !== 1'b1) begin failures++; $display("FAIL midrst_ro: got %0b want 1", net_ro); end
        nicEn = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pe_read(2'd3, d);
        asserts++; if (d !== 64'd0) begin failures++; $display("FAIL midrst_stat: got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_injection();
        test_out_full();
        test_ejection();
        test_back_to_back();
        test_empty_read();
        test_reset_mid_send();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/nic.md
# nic

PE-side network interface for one ring router node. It buffers 64-bit packets written by the processing element and injects them into the router's PE input port on the correct virtual-channel phase. It also accepts packets ejected from the router's PE output port and holds them until the processing element reads them. The NIC is the opposite endpoint of the router's pesi/pedi/peri and peso/pedo/pero handshake and is instantiated once per router node.

## Interface
- OUT_DEPTH, 4: output (injection) FIFO entries; power of two, 2..16
- IN_DEPTH, 4: input (ejection) FIFO entries; power of two, 2..16
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- addr  in  2  PE register select: 0 = input data, 1 = input status, 2 = output data, 3 = output status
- d_in  in  64  PE write data
- d_out  out  64  PE read data
- nicEn  in  1  PE access enable
- nicEnWr  in  1  1 = write, 0 = read (qualified by nicEn)
- net_polarity  in  1  router VC phase, toggles every cycle
- net_si  out  1  packet valid to router (router pesi)
- net_do  out  64  packet to router (router pedi)
- net_ri  in  1  router ready to accept (router peri)
- net_so  in  1  packet valid from router (router peso)
- net_di  in  64  packet from router (router pedo)
- net_ro  out  1  NIC ready to accept (router pero)

## Operation
- Packet format is transparent to the NIC: [63] VC, [62] direction, [61:56] reserved, [55:48] hop count, [47:32] reserved, [31:0] payload. The NIC never modifies a packet.
- **PE write, addr 2, nicEn & nicEnWr**
  - If the output FIFO is not full, push d_in.
  - If it is full, drop d_in silently. "Full" is evaluated before the edge, so a same-cycle network pop does not make room.
  - Writes to addr 0, 1 or 3 are ignored.
- **PE read, nicEn & ~nicEnWr** (d_out is combinational from registered state):
  - addr 0: head of the input FIFO. If the FIFO is non-empty, it pops at the edge. If empty, d_out = 0 and nothing pops.
  - addr 1: {48'b0, occupancy[7:0], 7'b0, nonempty}.
  - addr 2: 0.
  - addr 3: {48'b0, occupancy[7:0], 7'b0, full}.
  - When there is no read access, d_out = 0.
- **Injection state machine** (registered outputs):
  - IDLE: net_si = 0, net_do = 0. Move to SEND when all of the following hold at the edge: the output FIFO is non-empty, net_ri = 1, and head[63] != net_polarity (the VC bit must match the polarity of the following cycle).
  - On that transition, net_do <= head, net_si <= 1, and the FIFO pops.
  - SEND: lasts exactly one cycle.
    - Return to IDLE with net_si <= 0 and net_do <= 0 if the phase condition fails.
    - Otherwise, back-to-back sends are allowed: another entry is eligible on the next edge if the same conditions hold, but the phase condition normally forces one idle cycle.
  - If head[63] == net_polarity, wait in IDLE; the next cycle satisfies the condition.
- **Ejection**
  - net_ro = ~input FIFO full.
  - On an edge with net_so & net_ro, push net_di.
  - If net_so arrives while full, it is dropped; this is a protocol violation and the bench asserts on it.
- **Simultaneous events**
  - An input FIFO push and PE pop in the same cycle are both performed; occupancy is unchanged.
  - An output FIFO push and network pop in the same cycle are both performed.

## Timing
- Reset values: net_si = 0, net_do = 0, d_out = 0, net_ro = 1, both FIFOs empty, FSM in IDLE.
- Injection latency:
  - PE write at edge N makes the entry visible at N.
  - The earliest net_si is the cycle after edge N+1 (polarity-matching), otherwise after edge N+2.
- Ejection latency: a packet captured at edge N is readable on d_out (addr 0) in cycle N+1.
- Pointers wrap modulo depth. Occupancy is a log2(depth)+1 bit counter.
- Reset mid-operation: all in-flight packets are discarded and net_si drops immediately (asynchronously).

## Structure
- Shared package nic_pkg: address constants ADDR_IN_DATA/ADDR_IN_STAT/ADDR_OUT_DATA/ADDR_OUT_STAT, packet field bit positions (VC_BIT = 63, DIR_BIT = 62, HOP_MSB/LSB = 55/48), and the FSM state enum.
- One sub-module, nic_fifo (parameter DEPTH, WIDTH = 64, with push, pop, head, full, empty, count), instantiated twice.

## Test plan
- **Reset:** assert reset mid-send with net_si = 1 → net_si, net_do and d_out go to 0 immediately; net_ro = 1; after release, addr 3 reads 0.
- **Phase-correct injection:** write 64'h8000_0000_1234_5678 with net_ri = 1 → net_si pulses one cycle while net_polarity = 1 and net_do equals that value. Repeat with [63] = 0 → net_si pulses while net_polarity = 0.
- **Output full / drop:** hold net_ri = 0 and write 5 packets with OUT_DEPTH = 4 → addr 3 reads 0x0401; the 5th packet never appears; raising net_ri drains exactly 4 packets in order.
- **Ejection backpressure:** drive 4 packets via net_so with no PE reads → net_ro = 0 after the 4th; addr 1 reads 0x0401; one addr-0 read → data = 1st packet and net_ro = 1 the next cycle.
- **Simultaneous push/pop:** input FIFO holds 2 entries; net_so and an addr-0 read occur in the same cycle → occupancy stays 2 and order is preserved.
- **Empty read:** addr 0 read with the FIFO empty → d_out = 0 and occupancy stays 0.
